click_decoder: RTL and testbench

//  Receiver-side counterpart of the transmitter pulse generator. Samples the four

---
 rtl/click_decoder_if.sv | 13 +
 rtl/click_decoder.sv | 194 +++++++++++++++++++
 tb/tb_click_decoder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/click_decoder_if.sv
// Record readout channel of the click decoder: valid/ready handshake carrying
// the slot stamp and click code of the FIFO head record.
interface click_decoder_if #(
   parameter int unsigned SLOT_W = 32
);
   logic              rec_valid;
   logic              rec_ready;
   logic [SLOT_W-1:0] rec_slot;
   logic [4:0]        rec_code;

   modport master (output rec_valid, rec_slot, rec_code, input rec_ready);
   modport slave  (input rec_valid, rec_slot, rec_code, output rec_ready);
endinterface

// File: rtl/click_decoder.sv
// Classifies each detector slot as no/single/multi click, stamps click slots with
// a free-running slot index and buffers them in a record FIFO with saturating tallies.
module click_decoder #(
   parameter int unsigned SLOT_W     = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [3:0]                    clicks,
   input  logic                          clear_counts,
   click_decoder_if.master               rec,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          busy,
   output logic [CNT_W-1:0]              cnt_single,
   output logic [CNT_W-1:0]              cnt_multi,
   output logic [CNT_W-1:0]              cnt_dropped
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;

   logic              s1_valid_q;
   logic [3:0]        s1_mask_q;
   logic [SLOT_W-1:0] s1_slot_q;
   logic              s2_valid_q;
   logic [4:0]        s2_code_q;
   logic [SLOT_W-1:0] s2_slot_q;

   logic [SLOT_W-1:0] mem_slot_q [FIFO_DEPTH];
   logic [4:0]        mem_code_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              rec_valid_q;

   logic              pop_c, full_c, push_ok_c, drop_c;

   logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
   logic [CNT_W-1:0]  cnt_multi_q, cnt_multi_d;
   logic [CNT_W-1:0]  cnt_dropped_q, cnt_dropped_d;
   logic              overflow_q, overflow_d;
   logic              busy_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Acquisition control and slot index
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               slot_d  = '0;
            end
         end
         RUN: begin
            slot_d = slot_q + SLOT_W'(1);
            if (!enable) state_d = DRAIN;
         end
         DRAIN: begin
            if (enable) state_d = RUN;
            else if (level_q == '0 && !s1_valid_q && !s2_valid_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Two-stage sample/classify pipeline; a mask with two or more bits set is multi
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mask_q  <= '0;
         s1_slot_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_code_q  <= '0;
         s2_slot_q  <= '0;
      end else begin
         s1_valid_q <= (state_q == RUN) && (|clicks);
         s1_mask_q  <= clicks;
         s1_slot_q  <= slot_q;
         s2_valid_q <= s1_valid_q;
         s2_code_q  <= {|(s1_mask_q & (s1_mask_q - 4'd1)), s1_mask_q};
         s2_slot_q  <= s1_slot_q;
      end
   end

   // FIFO push/pop decisions; a pop frees room for a same-cycle push when full
   always_comb begin
      pop_c     = (level_q != '0) && rec.rec_ready;
      full_c    = (level_q == LVL_W'(FIFO_DEPTH));
      push_ok_c = s2_valid_q && (!full_c || pop_c);
      drop_c    = s2_valid_q && full_c && !pop_c;
      level_d   = level_q;
      case ({push_ok_c, pop_c})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_slot_q[i] <= '0;
            mem_code_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rec_valid_q <= 1'b0;
      end else begin
         if (push_ok_c) begin
            mem_slot_q[wr_ptr_q] <= s2_slot_q;
            mem_code_q[wr_ptr_q] <= s2_code_q;
            wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q     <= level_d;
         rec_valid_q <= (level_d != '0);
      end
   end

   // Tallies saturate; clear_counts overrides any same-cycle increment
   always_comb begin
      cnt_single_d  = cnt_single_q;
      cnt_multi_d   = cnt_multi_q;
      cnt_dropped_d = cnt_dropped_q;
      overflow_d    = overflow_q;
      if (clear_counts) begin
         cnt_single_d  = '0;
         cnt_multi_d   = '0;
         cnt_dropped_d = '0;
         overflow_d    = 1'b0;
      end else begin
         if (push_ok_c && !s2_code_q[4]) cnt_single_d = sat_inc(cnt_single_q);
         if (push_ok_c &&  s2_code_q[4]) cnt_multi_d  = sat_inc(cnt_multi_q);
         if (drop_c) begin
            cnt_dropped_d = sat_inc(cnt_dropped_q);
            overflow_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_single_q  <= '0;
         cnt_multi_q   <= '0;
         cnt_dropped_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         cnt_single_q  <= cnt_single_d;
         cnt_multi_q   <= cnt_multi_d;
         cnt_dropped_q <= cnt_dropped_d;
         overflow_q    <= overflow_d;
      end
   end

   assign rec.rec_valid = rec_valid_q;
   assign rec.rec_slot  = mem_slot_q[rd_ptr_q];
   assign rec.rec_code  = mem_code_q[rd_ptr_q];
   assign fifo_level    = level_q;
   assign overflow      = overflow_q;
   assign busy          = busy_q;
   assign cnt_single    = cnt_single_q;
   assign cnt_multi     = cnt_multi_q;
   assign cnt_dropped   = cnt_dropped_q;

endmodule

// File: tb/tb_click_decoder.sv
// Scoreboard bench for click_decoder: a slot-level reference model predicts records
// and tallies; a separate monitor checks every handshaken record against the queue.
module tb_click_decoder;

   localparam int unsigned SLOT_W = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = 5;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam int          M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              enable = 1'b0;
   logic [3:0]        clicks = 4'd0;
   logic              clear_counts = 1'b0;
   logic [4:0]        fifo_level;
   logic              overflow, busy;
   logic [CNT_W-1:0]  cnt_single, cnt_multi, cnt_dropped;

   click_decoder_if #(.SLOT_W(SLOT_W)) rec_if ();

   click_decoder #(.SLOT_W(SLOT_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clicks(clicks),
      .clear_counts(clear_counts), .rec(rec_if), .fifo_level(fifo_level),
      .overflow(overflow), .busy(busy), .cnt_single(cnt_single),
      .cnt_multi(cnt_multi), .cnt_dropped(cnt_dropped)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SLOT_W-1:0] slot;
      logic [4:0]        code;
   } rec_t;

   rec_t sb[$];
   rec_t pipe_r [2];
   bit   pipe_v [2];
   rec_t mon_e;
   int   m_mode, m_slot, m_level, m_single, m_multi, m_drop;
   bit   m_ovf;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? v : v + 1;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_slot = 0; m_level = 0;
      m_single = 0; m_multi = 0; m_drop = 0; m_ovf = 1'b0;
      pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
      sb.delete();
   endtask

   // Predict the effect of the next clock edge given the inputs driven for it
   task automatic model_edge(input bit en, input logic [3:0] ck, input bit rdy, input bit clr);
      bit pop;
      bit pipe_empty;
      int nmode, nslot;
      pop        = (m_level > 0) && rdy;
      pipe_empty = !pipe_v[0] && !pipe_v[1];
      nmode = m_mode;
      nslot = m_slot;
      if (m_mode == M_IDLE && en) begin
         nmode = M_RUN; nslot = 0;
      end else if (m_mode == M_RUN) begin
         nslot = (m_slot + 1) % (1 << SLOT_W);
         if (!en) nmode = M_DRAIN;
      end else if (m_mode == M_DRAIN) begin
         if (en) nmode = M_RUN;
         else if (m_level == 0 && pipe_empty) nmode = M_IDLE;
      end
      if (pipe_v[1]) begin
         if (m_level == int'(DEPTH) && !pop) begin
            m_drop = sat(m_drop);
            m_ovf  = 1'b1;
         end else begin
            sb.push_back(pipe_r[1]);
            m_level++;
            if (pipe_r[1].code[4]) m_multi = sat(m_multi);
            else m_single = sat(m_single);
         end
      end
      if (pop) m_level--;
      if (clr) begin
         m_single = 0; m_multi = 0; m_drop = 0; m_ovf = 1'b0;
      end
      pipe_v[1] = pipe_v[0];
      pipe_r[1] = pipe_r[0];
      pipe_v[0] = (m_mode == M_RUN) && (ck != 4'd0);
      pipe_r[0].slot = SLOT_W'(m_slot);
      pipe_r[0].code = {($countones(ck) >= 2), ck};
      m_mode = nmode;
      m_slot = nslot;
   endtask

   task automatic check_all();
      chk("fifo_level", 64'(fifo_level), 64'(m_level));
      chk("rec_valid", 64'(rec_if.rec_valid), 64'(m_level > 0));
      chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("cnt_single", 64'(cnt_single), 64'(m_single));
      chk("cnt_multi", 64'(cnt_multi), 64'(m_multi));
      chk("cnt_dropped", 64'(cnt_dropped), 64'(m_drop));
   endtask

   // One slot: check current outputs, drive inputs, advance model and clock
   task automatic step(input bit en, input logic [3:0] ck, input bit rdy, input bit clr);
      check_all();
      enable = en; clicks = ck; rec_if.rec_ready = rdy; clear_counts = clr;
      model_edge(en, ck, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      enable = 1'b0; clicks = 4'd0; rec_if.rec_ready = 1'b0; clear_counts = 1'b0;
      #1;
      chk({tag, "_rec_valid"}, 64'(rec_if.rec_valid), 64'd0);
      chk({tag, "_level"}, 64'(fifo_level), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_rec_slot"}, 64'(rec_if.rec_slot), 64'd0);
      chk({tag, "_rec_code"}, 64'(rec_if.rec_code), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
      chk({tag, "_cnts"}, 64'({cnt_single, cnt_multi, cnt_dropped}), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted record must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rec_if.rec_valid && rec_if.rec_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_record actual_slot=%0d actual_code=%0d expected=none",
                        rec_if.rec_slot, rec_if.rec_code);
            end else begin
               mon_e = sb.pop_front();
               chk("mon_slot", 64'(rec_if.rec_slot), 64'(mon_e.slot));
               chk("mon_code", 64'(rec_if.rec_code), 64'(mon_e.code));
            end
         end
      end
   end

   initial begin
      int hold;
      bit en, rdy;
      rec_if.rec_ready = 1'b0;
      model_reset();
      #2;
      do_reset("reset");

      // Single click at slot 5, then H+V multi click at slot 7
      step(1, 4'd0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 4'd0, 1, 0);
      step(1, 4'b0001, 1, 0);
      step(1, 4'd0, 1, 0);
      step(1, 4'b0011, 1, 0);
      chk("t1_valid", 64'(rec_if.rec_valid), 64'd1);
      chk("t1_slot", 64'(rec_if.rec_slot), 64'd5);
      chk("t1_code", 64'(rec_if.rec_code), 64'b00001);
      chk("t1_single", 64'(cnt_single), 64'd1);
      step(1, 4'd0, 1, 0);
      step(1, 4'd0, 1, 0);
      chk("t2_slot", 64'(rec_if.rec_slot), 64'd7);
      chk("t2_code", 64'(rec_if.rec_code), 64'b10011);
      chk("t2_multi", 64'(cnt_multi), 64'd1);
      chk("t2_single", 64'(cnt_single), 64'd1);
      step(1, 4'd0, 1, 0);

      // 20 click slots with consumer stalled overflow a 16-deep FIFO
      step(1, 4'd0, 1, 1);
      for (int i = 0; i < 20; i++) step(1, 4'($urandom_range(1, 15)), 0, 0);
      step(1, 4'd0, 0, 0);
      step(1, 4'd0, 0, 0);
      chk("t3_level", 64'(fifo_level), 64'd16);
      chk("t3_dropped", 64'(cnt_dropped), 64'd4);
      chk("t3_overflow", 64'(overflow), 64'd1);
      for (int i = 0; i < 20; i++) step(1, 4'd0, 1, 0);
      step(1, 4'd0, 1, 1);
      chk("t3_clr_overflow", 64'(overflow), 64'd0);
      chk("t3_clr_cnts", 64'({cnt_single, cnt_multi, cnt_dropped}), 64'd0);

      // Full FIFO: push and pop on the same edge keep the level, no drop
      for (int i = 0; i < 16; i++) step(1, 4'($urandom_range(1, 15)), 0, 0);
      step(1, 4'd0, 0, 0);
      step(1, 4'd0, 0, 0);
      chk("t4_full", 64'(fifo_level), 64'd16);
      step(1, 4'b0100, 0, 0);
      step(1, 4'd0, 0, 0);
      step(1, 4'd0, 1, 0);
      chk("t4_level", 64'(fifo_level), 64'd16);
      chk("t4_dropped", 64'(cnt_dropped), 64'd0);
      for (int i = 0; i < 20; i++) step(1, 4'd0, 1, 0);

      // Slot index wraps 15 -> 0 with a 4-bit slot field
      do_reset("t5_reset");
      step(1, 4'd0, 0, 0);
      for (int i = 0; i < 15; i++) step(1, 4'd0, 0, 0);
      step(1, 4'b1000, 0, 0);
      step(1, 4'b0010, 0, 0);
      step(1, 4'd0, 0, 0);
      chk("t5_slot15", 64'(rec_if.rec_slot), 64'd15);
      chk("t5_code15", 64'(rec_if.rec_code), 64'b01000);
      step(1, 4'd0, 1, 0);
      chk("t5_slot0", 64'(rec_if.rec_slot), 64'd0);
      chk("t5_code0", 64'(rec_if.rec_code), 64'b00010);
      step(1, 4'd0, 1, 0);
      step(1, 4'd0, 1, 0);

      // Reset while draining with records buffered
      for (int i = 0; i < 5; i++) step(1, 4'($urandom_range(1, 15)), 0, 0);
      step(0, 4'd0, 0, 0);
      step(0, 4'd0, 0, 0);
      chk("t6_busy", 64'(busy), 64'd1);
      chk("t6_level", 64'(fifo_level), 64'd5);
      do_reset("t6_reset");

      // Randomised acquisition windows, stalls and clears
      en = 1'b1; rdy = 1'b1; hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            en   = ($urandom_range(0, 4) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            hold = int'($urandom_range(1, 40));
         end
         hold--;
         step(en,
              ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
              rdy ? ($urandom_range(0, 4) != 0) : 1'b0,
              ($urandom_range(0, 199) == 0));
      end

      // Final drain, bounded
      for (int i = 0; i < 100; i++) begin
         if (m_mode == M_IDLE && m_level == 0) break;
         step(0, 4'd0, 1, 0);
      end
      check_all();
      chk("final_idle", 64'(m_mode), 64'(M_IDLE));
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
